// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
//  Module      : song_reader
//  Description : Walks {note,duration} words of the selected song in ROM and
//                hands each to the note player; reports end of song.
//  Revision    : 1.0 - initial release
// ============================================================================
module song_reader #(
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5,
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic                          reset_play,
    input  logic                          NextSong,
    input  logic                          note_done,
    output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       rom_data,
    output logic [NOTE_W-1:0]             note,
    output logic [DUR_W-1:0]              duration,
    output logic                          new_note,
    output logic                          song_done,
    output logic [SONG_BITS-1:0]          song
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_WAIT_ROM  = 3'd2;
    localparam logic [2:0] c_ISSUE     = 3'd3;
    localparam logic [2:0] c_WAIT_NOTE = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;

    localparam logic [IDX_BITS-1:0]  c_LAST_IDX = '1;
    localparam logic [IDX_BITS-1:0]  c_IDX_INC  = 1;
    localparam logic [SONG_BITS-1:0] c_SONG_INC = 1;

    logic [2:0]           r_state;
    logic [SONG_BITS-1:0] r_song;
    logic [IDX_BITS-1:0]  r_idx;
    logic [NOTE_W-1:0]    r_note;
    logic [DUR_W-1:0]     r_dur;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_song  <= '0;
            r_idx   <= '0;
            r_note  <= '0;
            r_dur   <= '0;
        end else if (reset_play || NextSong) begin
            // Either control aborts the current fetch/note and restarts at slot 0.
            r_state <= c_IDLE;
            r_idx   <= '0;
            if (NextSong) begin
                r_song <= r_song + c_SONG_INC;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (play) begin
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_state <= c_WAIT_ROM;
                end
                c_WAIT_ROM: begin
                    r_note  <= rom_data[NOTE_W+DUR_W-1:DUR_W];
                    r_dur   <= rom_data[DUR_W-1:0];
                    r_state <= (rom_data[DUR_W-1:0] == '0) ? c_DONE : c_ISSUE;
                end
                c_ISSUE: begin
                    if (play) begin
                        r_state <= c_WAIT_NOTE;
                    end
                end
                c_WAIT_NOTE: begin
                    if (note_done) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_DONE;
                        end else begin
                            r_idx   <= r_idx + c_IDX_INC;
                            r_state <= c_FETCH;
                        end
                    end
                end
                c_DONE: begin
                    r_idx   <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = {r_song, r_idx};
    assign note      = r_note;
    assign duration  = r_dur;
    assign song      = r_song;
    assign new_note  = (r_state == c_ISSUE) && play;
    assign song_done = (r_state == c_DONE);

endmodule
`default_nettype wire
